serial_add_sequencer: RTL and testbench

Control and datapath stage that wraps the one-bit serial adder used in this codebase. The block accepts two WIDTH-bit operands through a valid/ready handshake and presents them LSB-first to the adder, one bit per clock. It collects the adder's sum bit each cycle and returns the parallel sum, carry-out and signed-overflow flag through a second valid/ready handshake. It sits directly upstream (operand bits, carry clear) and downstream (sum and carry bits) of the serial adder.

---
 rtl/serial_add_sequencer.sv | 113 +++++++++++
 tb/tb_serial_add_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sequencer.sv
// Operand sequencer for the one-bit serial adder: accepts a parallel operand
// pair, streams it LSB-first into the adder and reassembles the parallel sum,
// carry-out and signed-overflow flag behind a valid/ready result handshake.
module serial_add_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ser_a,
  output logic             ser_b,
  output logic             carry_clr,
  input  logic             ser_s,
  input  logic             ser_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntMsbIn = CntW'(WIDTH - 2);
  localparam logic [CntW-1:0] CntLast  = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StClear, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             c_msb_in_q, c_msb_in_d;
  logic             cout_q, cout_d;

  // State and datapath registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      sum_sh_q   <= '0;
      cnt_q      <= '0;
      c_msb_in_q <= 1'b0;
      cout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      sum_sh_q   <= sum_sh_d;
      cnt_q      <= cnt_d;
      c_msb_in_q <= c_msb_in_d;
      cout_q     <= cout_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    sum_sh_d   = sum_sh_q;
    cnt_d      = cnt_q;
    c_msb_in_d = c_msb_in_q;
    cout_d     = cout_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_sh_d     = op_a;
          b_sh_d     = op_b;
          sum_sh_d   = '0;
          cnt_d      = '0;
          c_msb_in_d = 1'b0;
          cout_d     = 1'b0;
          state_d    = StClear;
        end
      end
      StClear: state_d = StShift;
      StShift: begin
        sum_sh_d = {ser_s, sum_sh_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        // Carry out of bit WIDTH-2 is the carry into the MSB.
        if (cnt_q == CntMsbIn) c_msb_in_d = ser_cout;
        if (cnt_q == CntLast) begin
          cout_d  = ser_cout;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    in_ready  = (state_q == StIdle);
    carry_clr = (state_q == StClear);
    ser_a     = (state_q == StShift) & a_sh_q[0];
    ser_b     = (state_q == StShift) & b_sh_q[0];
    out_valid = (state_q == StDone);
    sum       = sum_sh_q;
    cout      = cout_q;
    ovf       = c_msb_in_q ^ cout_q;
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Bench for serial_add_sequencer: two instances (WIDTH 8 and 16), each wired
// to a behavioural one-bit serial adder with a clearable carry register.
module tb_serial_add_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid[2], out_ready[2];
  logic        in_ready[2], ser_a[2], ser_b[2], carry_clr[2], ser_s[2], ser_cout[2];
  logic        out_valid[2], cout[2], ovf[2];
  logic [15:0] op_a[2], op_b[2], sum_n[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned W = (g == 0) ? 8 : 16;
    logic [W-1:0] s;
    logic         c_q = 1'b0;

    serial_add_sequencer #(.WIDTH(W)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .op_a      (op_a[g][W-1:0]),
      .op_b      (op_b[g][W-1:0]),
      .ser_a     (ser_a[g]),
      .ser_b     (ser_b[g]),
      .carry_clr (carry_clr[g]),
      .ser_s     (ser_s[g]),
      .ser_cout  (ser_cout[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .sum       (s),
      .cout      (cout[g]),
      .ovf       (ovf[g])
    );
    assign sum_n[g] = 16'(s);

    // Serial adder: full adder with a carry register cleared by carry_clr.
    always @(posedge clk) c_q <= carry_clr[g] ? 1'b0 : ser_cout[g];
    assign ser_s[g]    = ser_a[g] ^ ser_b[g] ^ c_q;
    assign ser_cout[g] = (ser_a[g] & ser_b[g]) | (c_q & (ser_a[g] ^ ser_b[g]));
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer addition and the signed-overflow sign rule.
  task automatic model(input int w, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] s, output logic c, output logic o);
    int unsigned mask, ai, bi, full;
    mask = (32'd1 << w) - 1;
    ai   = a & mask;
    bi   = b & mask;
    full = ai + bi;
    s    = 16'(full & mask);
    c    = full[w];
    o    = (ai[w-1] == bi[w-1]) && (s[w-1] != ai[w-1]);
  endtask

  // One full transaction with protocol checks; returns the captured result.
  task automatic do_op(input int i, input logic [15:0] a, input logic [15:0] b,
                       input int stall, output logic [15:0] s, output logic c,
                       output logic o);
    int w, n, clr_n, clr_pos, ser_err;
    bit seen;
    w = (i == 0) ? 8 : 16;
    @(negedge clk);
    op_a[i] = a; op_b[i] = b; in_valid[i] = 1'b1;
    chk("accept_ready", 32'(in_ready[i]), 32'd1);
    n = 1; clr_n = 0; clr_pos = -1; ser_err = 0; seen = 0;
    @(negedge clk);
    in_valid[i] = 1'b0;
    while (n < w + 10) begin
      if (carry_clr[i]) begin clr_n++; clr_pos = n; end
      if (n == 1 && (ser_a[i] || ser_b[i])) ser_err++;
      if (n >= 2 && n <= w + 1 && (ser_a[i] !== a[n-2] || ser_b[i] !== b[n-2])) ser_err++;
      if (out_valid[i]) begin seen = 1; break; end
      out_ready[i] = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(w + 2));
    s = sum_n[i]; c = cout[i]; o = ovf[i];
    if (!seen) return;
    chk("clr_count", 32'(clr_n), 32'd1);
    chk("clr_pos", 32'(clr_pos), 32'd1);
    chk("ser_bits", 32'(ser_err), 32'd0);
    for (int k = 0; k < stall; k++) begin
      out_ready[i] = 1'b0;
      in_valid[i]  = 1'b1;
      op_a[i] = 16'($urandom); op_b[i] = 16'($urandom);
      @(negedge clk);
      chk("stall_valid", 32'(out_valid[i]), 32'd1);
      chk("stall_ready", 32'(in_ready[i]), 32'd0);
      chk("stall_sum", 32'(sum_n[i]), 32'(s));
      chk("stall_flags", {30'd0, cout[i], ovf[i]}, {30'd0, c, o});
    end
    out_ready[i] = 1'b1;
    @(negedge clk);
    in_valid[i]  = 1'b0;
    out_ready[i] = 1'b0;
    chk("xfer_valid", 32'(out_valid[i]), 32'd0);
    chk("xfer_ready", 32'(in_ready[i]), 32'd1);
  endtask

  typedef struct {
    logic [7:0] a, b, s;
    logic       c, o;
    int         stall;
  } vec_t;

  initial begin
    vec_t        tbl[8];
    logic [15:0] s, es, ra, rb;
    logic        c, o, ec, eo;

    tbl[0] = '{8'h5A, 8'h33, 8'h8D, 1'b0, 1'b1, 0};
    tbl[1] = '{8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 0};
    tbl[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 0};
    tbl[3] = '{8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 0};
    tbl[4] = '{8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 2};
    tbl[5] = '{8'hC0, 8'hC0, 8'h80, 1'b1, 1'b0, 5};
    tbl[6] = '{8'h01, 8'hFE, 8'hFF, 1'b0, 1'b0, 0};
    tbl[7] = '{8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1};

    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b0; op_a[i] = '0; op_b[i] = '0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_in_ready", 32'(in_ready[i]), 32'd1);
      chk("rst_out_valid", 32'(out_valid[i]), 32'd0);
      chk("rst_sum", 32'(sum_n[i]), 32'd0);
      chk("rst_ser", {29'd0, ser_a[i], ser_b[i], carry_clr[i]}, 32'd0);
    end
    rst = 1'b0;

    for (int t = 0; t < 8; t++) begin
      do_op(0, 16'(tbl[t].a), 16'(tbl[t].b), tbl[t].stall, s, c, o);
      chk("vec_sum", 32'(s), 32'(tbl[t].s));
      chk("vec_cout", 32'(c), 32'(tbl[t].c));
      chk("vec_ovf", 32'(o), 32'(tbl[t].o));
    end

    // Reset during the 4th SHIFT cycle.
    @(negedge clk);
    op_a[0] = 16'h5A; op_b[0] = 16'h33; in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready[0]), 32'd1);
    chk("midrst_out_valid", 32'(out_valid[0]), 32'd0);
    chk("midrst_sum", 32'(sum_n[0]), 32'd0);
    chk("midrst_flags", {30'd0, cout[0], ovf[0]}, 32'd0);
    chk("midrst_ser", {29'd0, ser_a[0], ser_b[0], carry_clr[0]}, 32'd0);
    do_op(0, 16'h12, 16'h34, 0, s, c, o);
    chk("post_rst_sum", 32'(s), 32'h46);
    chk("post_rst_flags", {30'd0, c, o}, 32'd0);

    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 1000; k++) begin
        ra = 16'($urandom); rb = 16'($urandom);
        do_op(i, ra, rb, ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)),
              s, c, o);
        model((i == 0) ? 8 : 16, ra, rb, es, ec, eo);
        chk("rnd_sum", 32'(s), 32'(es));
        chk("rnd_cout", 32'(c), 32'(ec));
        chk("rnd_ovf", 32'(o), 32'(eo));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
